pe_arr_drain: RTL and testbench

- Result collector for the systolic PE array. It sits on the array's `outs`/`outvalids` side and is the reader for the array's result writer.
- Captures one result per PE as each PE raises its valid, holding them in a local buffer.
- Once all ROWS*COLS results are held, streams them out row-major (index = col + row*COLS) over a valid/ready interface to the downstream consumer (accumulator/SRAM writer), then re-arms for the next tile.

---
 rtl/pe_pkg.sv | 28 ++
 rtl/pe_drain_mux.sv | 31 +++
 rtl/pe_arr_drain.sv | 159 +++++++++++++++
 tb/tb_pe_arr_drain.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared definitions for the array-side blocks of the
//                systolic PE array: drain state encoding and the helper
//                that sizes a PE index from the array geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } drain_state_t;

    // Explicit-width encodings used by the state registers
    localparam logic [0:0] c_ST_COLLECT = COLLECT;
    localparam logic [0:0] c_ST_DRAIN   = DRAIN;

    // Width of a PE index; a 1x1 array still gets a 1-bit index
    function automatic int idx_width(input int rows, input int cols);
        int n;
        n = rows * cols;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_drain_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pe_drain_mux
//  Description : Read mux over the registered result buffer. Selects the
//                entry addressed by idx; an out-of-range idx reads zero.
//  Ports       : buf_data  in   OUTWIDTH x DEPTH  buffered results
//                idx       in   IDXW              entry select
//                data      out  OUTWIDTH          selected entry
//  Revision    : 1.0  initial release
// ============================================================================
module pe_drain_mux #(
    parameter int OUTWIDTH = 32,
    parameter int DEPTH    = 64,
    parameter int IDXW     = 6
) (
    input  logic [OUTWIDTH-1:0] buf_data [DEPTH],
    input  logic [IDXW-1:0]     idx,
    output logic [OUTWIDTH-1:0] data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == IDXW'(i)) begin
                data = buf_data[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_arr_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pe_arr_drain
//  Description : Result collector for the systolic PE array. Captures one
//                result per PE on the rising edge of its valid, and once all
//                ROWS*COLS results are held, streams them out row-major
//                (index = col + row*COLS) over valid/ready, then re-arms.
//  Ports       : clk       in   1                  clock, rising edge
//                rst       in   1                  async active-high reset
//                in_res    in   OUTWIDTH x N       PE results, row-major
//                in_valid  in   1 x N              per-PE result valid
//                flush     in   1                  sync abort to COLLECT
//                m_data    out  OUTWIDTH           streamed result
//                m_idx     out  IDXW               PE index of m_data
//                m_last    out  1                  final element of tile
//                m_valid   out  1                  stream valid
//                m_ready   in   1                  stream ready
//                busy      out  1                  draining
//                overrun   out  1                  sticky error flag
//  Revision    : 1.0  initial release
// ============================================================================
module pe_arr_drain
    import pe_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int IDXW     = idx_width(ROWS, COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OUTWIDTH-1:0] in_res   [ROWS*COLS],
    input  logic                in_valid [ROWS*COLS],
    input  logic                flush,
    output logic [OUTWIDTH-1:0] m_data,
    output logic [IDXW-1:0]     m_idx,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int              c_N    = ROWS * COLS;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(c_N - 1);

    logic [0:0]          r_state;
    logic [c_N-1:0]      r_captured;
    logic [c_N-1:0]      r_valid_q;
    logic [IDXW-1:0]     r_idx;
    logic                r_overrun;
    logic [OUTWIDTH-1:0] r_buf [c_N];

    logic [c_N-1:0]      w_rise;
    logic [c_N-1:0]      w_new_cap;
    logic [c_N-1:0]      w_cap_next;
    logic                w_all_cap;
    logic                w_dup_evt;
    logic                w_draining;
    logic                w_xfer;
    logic                w_is_last;
    logic [OUTWIDTH-1:0] w_mux_data;

    // ------------------------------------------------------------------
    // Rise detection and capture decode
    // ------------------------------------------------------------------
    always_comb begin
        w_rise = '0;
        for (int k = 0; k < c_N; k++) begin
            w_rise[k] = in_valid[k] & ~r_valid_q[k];
        end
    end

    assign w_draining = (r_state == c_ST_DRAIN);
    assign w_new_cap  = w_draining ? '0 : (w_rise & ~r_captured);
    assign w_cap_next = r_captured | w_new_cap;
    assign w_all_cap  = &w_cap_next;
    // Any rise while draining, or a second rise on an already-held PE
    assign w_dup_evt  = w_draining ? (|w_rise) : (|(w_rise & r_captured));
    assign w_xfer     = w_draining & m_ready;
    assign w_is_last  = (r_idx == c_LAST);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_COLLECT;
            r_captured <= '0;
            r_valid_q  <= '0;
            r_idx      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            for (int k = 0; k < c_N; k++) begin
                r_valid_q[k] <= in_valid[k];
            end

            if (w_dup_evt) begin
                r_overrun <= 1'b1;
            end

            if (flush) begin
                // Flush wins over any capture or handshake this cycle
                r_state    <= c_ST_COLLECT;
                r_captured <= '0;
                r_idx      <= '0;
            end else if (!w_draining) begin
                r_captured <= w_cap_next;
                if (w_all_cap) begin
                    r_state <= c_ST_DRAIN;
                    r_idx   <= '0;
                end
            end else if (w_xfer) begin
                if (w_is_last) begin
                    r_state    <= c_ST_COLLECT;
                    r_captured <= '0;
                    r_idx      <= '0;
                end else begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result buffer: contents are only meaningful where captured is set,
    // so it carries no reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_N; k++) begin
            if (!flush && w_new_cap[k]) begin
                r_buf[k] <= in_res[k];
            end
        end
    end

    pe_drain_mux #(
        .OUTWIDTH (OUTWIDTH),
        .DEPTH    (c_N),
        .IDXW     (IDXW)
    ) u_mux (
        .buf_data (r_buf),
        .idx      (r_idx),
        .data     (w_mux_data)
    );

    // ------------------------------------------------------------------
    // Stream outputs come from registered state only; gating with the
    // state keeps m_data at zero outside a drain
    // ------------------------------------------------------------------
    assign m_valid = w_draining;
    assign busy    = w_draining;
    assign m_idx   = w_draining ? r_idx : '0;
    assign m_last  = w_draining & w_is_last;
    assign m_data  = w_draining ? w_mux_data : '0;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pe_arr_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_arr_drain
//  Description : Self-checking bench for pe_arr_drain on a 2x2 array.
//                Expected beats are queued when results are driven and
//                compared as the stream delivers them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_arr_drain;

    localparam int c_N = 4;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [31:0] in_res   [c_N];
    logic        in_valid [c_N];
    logic        flush;
    logic [31:0] m_data;
    logic [1:0]  m_idx;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        overrun;

    beat_t sb_q [$];
    int    checks   = 0;
    int    failures = 0;

    pe_arr_drain #(
        .ROWS     (2),
        .COLS     (2),
        .OUTWIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_res   (in_res),
        .in_valid (in_valid),
        .flush    (flush),
        .m_data   (m_data),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no checking)
    task automatic clear_valids();
        for (int j = 0; j < c_N; j++) in_valid[j] = 1'b0;
    endtask

    task automatic push_beat(input int k, input logic [31:0] d);
        beat_t e;
        e.idx  = 2'(k);
        e.data = d;
        e.last = (k == c_N - 1);
        sb_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        for (int j = 0; j < c_N; j++) begin in_res[j] = '0; in_valid[j] = 1'b0; end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            m_last !== 1'b0 || m_idx !== 2'd0 || m_data !== 32'd0) begin
            failures++;
            $display("FAIL reset: valid=%b busy=%b ovr=%b last=%b idx=%0d data=%h, expected all zero",
                     m_valid, busy, overrun, m_last, m_idx, m_data);
        end
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_staggered();
        beat_t e;
        int got = 0;
        m_ready = 1'b1;
        for (int k = 0; k < c_N; k++) begin
            @(negedge clk);
            clear_valids();
            checks++;
            if (m_valid !== 1'b0) begin
                failures++;
                $display("FAIL stag_early_valid: m_valid=%b before capture %0d, expected 0", m_valid, k);
            end
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h10 + 32'(k);
            push_beat(k, 32'h10 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL stag_latency: m_valid=%b one cycle after last capture, expected 1", m_valid);
        end
        for (int c = 0; c < 30; c++) begin
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL stag_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL stag_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == c_N) break;
            @(negedge clk);
        end
        checks++;
        if (got != c_N) begin
            failures++;
            $display("FAIL stag_count: got %0d beats, expected %0d", got, c_N);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL stag_end: valid=%b busy=%b ovr=%b, expected 0 0 0", m_valid, busy, overrun);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_level();
        beat_t e;
        int got = 0;
        m_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            in_valid[k] = 1'b1;
            in_res[k]   = 32'hA0 + 32'(k);
            push_beat(k, 32'hA0 + 32'(k));
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL level_latency: m_valid=%b, expected 1", m_valid);
        end
        for (int c = 0; c < 30; c++) begin
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL level_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL level_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == c_N) break;
            @(negedge clk);
        end
        checks++;
        if (got != c_N) begin
            failures++;
            $display("FAIL level_count: got %0d beats, expected %0d", got, c_N);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL level_recapture: m_valid=%b with valids held, expected 0", m_valid);
        end
        clear_valids();
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        beat_t e;
        int got = 0;
        int stall = 0;
        m_ready = 1'b1;
        for (int k = 0; k < c_N; k++) begin
            @(negedge clk);
            clear_valids();
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h10 + 32'(k);
            push_beat(k, 32'h10 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        for (int c = 0; c < 40; c++) begin
            if (got == 1 && stall < 3) begin
                m_ready = 1'b0;
                stall++;
                checks++;
                if (m_valid !== 1'b1 || m_idx !== 2'd1 || m_data !== 32'h11 || m_last !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_hold: valid=%b idx=%0d data=%h last=%b, expected 1 1 00000011 0",
                             m_valid, m_idx, m_data, m_last);
                end
            end else begin
                m_ready = 1'b1;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL bp_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == c_N) break;
            @(negedge clk);
        end
        checks++;
        if (got != c_N || sb_q.size() != 0 || stall != 3) begin
            failures++;
            $display("FAIL bp_count: beats=%0d left=%0d stalls=%0d, expected 4 0 3", got, sb_q.size(), stall);
        end
        @(negedge clk);
        m_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_overrun();
        beat_t e;
        int got = 0;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clear_valids();
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h10 + 32'(k);
            push_beat(k, 32'h10 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        @(negedge clk);
        in_valid[2] = 1'b1;
        in_res[2]   = 32'hFF;
        @(negedge clk);
        clear_valids();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_collect: overrun=%b after duplicate rise, expected 1", overrun);
        end
        in_valid[3] = 1'b1;
        in_res[3]   = 32'h13;
        push_beat(3, 32'h13);
        @(negedge clk);
        clear_valids();
        // Rise on PE 1 while draining: flagged, data ignored
        in_valid[1] = 1'b1;
        in_res[1]   = 32'h55;
        @(negedge clk);
        clear_valids();
        m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL ovr_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL ovr_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == c_N) break;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (got != c_N || overrun !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_end: beats=%0d overrun=%b valid=%b, expected 4 1 0", got, overrun, m_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        beat_t e;
        int got = 0;
        m_ready = 1'b1;
        for (int k = 0; k < c_N; k++) begin
            @(negedge clk);
            clear_valids();
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h10 + 32'(k);
            if (k < 2) push_beat(k, 32'h10 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        for (int c = 0; c < 30; c++) begin
            if (got == 1) flush = 1'b1;
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL flush_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL flush_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == 2) break;
            @(negedge clk);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (got != 2 || m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL flush_abort: beats=%0d valid=%b busy=%b ovr=%b, expected 2 0 0 1",
                     got, m_valid, busy, overrun);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: m_valid=%b, expected 0", m_valid);
        end
        for (int k = 0; k < c_N; k++) begin
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h20 + 32'(k);
            push_beat(k, 32'h20 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL flush_new_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL flush_new_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == c_N) break;
            @(negedge clk);
        end
        checks++;
        if (got != c_N) begin
            failures++;
            $display("FAIL flush_new_count: got %0d beats, expected %0d", got, c_N);
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        beat_t e;
        int got = 0;
        m_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h30 + 32'(k);
            push_beat(k, 32'h30 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        for (int c = 0; c < 30; c++) begin
            if (got == 2) break;
            if (m_valid && m_ready) begin
                checks++;
                e = sb_q.pop_front();
                if (m_idx !== e.idx || m_data !== e.data) begin
                    failures++;
                    $display("FAIL arst_beat: got idx=%0d data=%h, expected idx=%0d data=%h",
                             m_idx, m_data, e.idx, e.data);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd2) begin
            failures++;
            $display("FAIL arst_pre: valid=%b idx=%0d, expected 1 2", m_valid, m_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL arst_now: valid=%b busy=%b ovr=%b, expected 0 0 0", m_valid, busy, overrun);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_idle: m_valid=%b, expected 0", m_valid);
        end
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b1;
            in_res[k]   = 32'h40 + 32'(k);
            push_beat(k, 32'h40 + 32'(k));
        end
        @(negedge clk);
        clear_valids();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_partial: m_valid=%b with 3 of 4 captured, expected 0", m_valid);
        end
        in_valid[3] = 1'b1;
        in_res[3]   = 32'h43;
        push_beat(3, 32'h43);
        @(negedge clk);
        clear_valids();
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (m_valid && m_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL arst_new_beat: unexpected beat idx=%0d, expected none", m_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_idx !== e.idx || m_data !== e.data || m_last !== e.last) begin
                        failures++;
                        $display("FAIL arst_new_beat: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                                 m_idx, m_data, m_last, e.idx, e.data, e.last);
                    end
                end
                got++;
            end
            if (got == c_N) break;
            @(negedge clk);
        end
        checks++;
        if (got != c_N) begin
            failures++;
            $display("FAIL arst_new_count: got %0d beats, expected %0d", got, c_N);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_staggered();
        test_level();
        test_backpressure();
        test_overrun();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
